// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register
//   ID/EX pipeline register for a 5-stage RISC-V style core.
//   Every output is a flop; D inputs captured on posedge appear on the E
//   outputs one cycle later.
//   Per-edge priority: rst > FlushE > StallE > load.
//   A load performs a write-through bypass from the writeback write port.
//   This covers the case where the register file is written in the same
//   cycle it is read.
//   A load with ValidD=0 becomes a bubble: control is cleared and data is
//   loaded normally.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   StallE, FlushE                 hold / bubble-insert for the E stage
//   ValidD, PCD .. ALUControlD     decode-stage slot contents
//   RegWriteW, RdW, ResultW        writeback write port (bypass source)
//   ValidE, PCE .. ALUControlE     registered E-stage copies
//   BubbleCount                    saturating count of inserted bubbles
module id_ex_pipeline_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  ResultW,
  output logic             ValidE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [CNT_W-1:0] BubbleCount
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
  logic             byp1, byp2, bubble;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  assign byp1 = RegWriteW && (RdW != 5'd0) && (RdW == Rs1D);
  assign byp2 = RegWriteW && (RdW != 5'd0) && (RdW == Rs2D);

  always_comb begin
    ex_d      = ex_q;
    bub_cnt_d = bub_cnt_q;
    bubble    = 1'b0;
    if (FlushE) begin
      ex_d   = '0;
      bubble = 1'b1;
    end else if (!StallE) begin
      ex_d.pc  = PCD;
      ex_d.pc4 = PCPlus4D;
      ex_d.imm = ImmExtD;
      ex_d.rd1 = byp1 ? ResultW : RD1D;
      ex_d.rd2 = byp2 ? ResultW : RD2D;
      ex_d.rs1 = Rs1D;
      ex_d.rs2 = Rs2D;
      ex_d.rd  = RdD;
      // Control only survives for a real instruction, which keeps all
      // control outputs zero whenever ValidE is low.
      ex_d.valid      = ValidD;
      ex_d.reg_write  = ValidD & RegWriteD;
      ex_d.mem_write  = ValidD & MemWriteD;
      ex_d.jump       = ValidD & JumpD;
      ex_d.branch     = ValidD & BranchD;
      ex_d.alu_src    = ValidD & ALUSrcD;
      ex_d.result_src = ValidD ? ResultSrcD  : 2'd0;
      ex_d.alu_ctrl   = ValidD ? ALUControlD : 3'd0;
      bubble          = !ValidD;
    end
    if (bubble && (bub_cnt_q != {CNT_W{1'b1}}))
      bub_cnt_d = bub_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      bub_cnt_q <= '0;
    end else begin
      ex_q      <= ex_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign ValidE      = ex_q.valid;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc4;
  assign ImmExtE     = ex_q.imm;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcE     = ex_q.alu_src;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_ctrl;
  assign BubbleCount = bub_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Scoreboard bench for id_ex_pipeline_register (XLEN=32, CNT_W=4).
// Expected E-stage contents are predicted when stimulus is driven, pushed to
// a queue, then popped and compared one posedge later.
module tb_id_ex_pipeline_register;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic StallE, FlushE, ValidD;
  logic [XLEN-1:0] PCD, PCPlus4D, ImmExtD, RD1D, RD2D, ResultW;
  logic [4:0] Rs1D, Rs2D, RdD, RdW;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, RegWriteW;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic ValidE;
  logic [XLEN-1:0] PCE, PCPlus4E, ImmExtE, RD1E, RD2E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [CNT_W-1:0] BubbleCount;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .RD1D(RD1D), .RD2D(RD2D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .ValidE(ValidE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .RD1E(RD1E), .RD2E(RD2E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .BubbleCount(BubbleCount)
  );

  typedef struct packed {
    logic v;
    logic [XLEN-1:0] pc, pc4, imm, rd1, rd2;
    logic [4:0] rs1, rs2, rd;
    logic rw, mw, j, b, as;
    logic [1:0] rsrc;
    logic [2:0] alu;
    logic [CNT_W-1:0] bc;
  } st_t;

  st_t m;          // model of E-stage state
  st_t sb[$];      // expected outputs awaiting the next posedge
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic st_t predict(input st_t cur);
    st_t n = cur;
    if (FlushE) begin
      n = '0;
      n.bc = (cur.bc == 4'hF) ? cur.bc : cur.bc + 4'd1;
    end else if (!StallE) begin
      n.pc = PCD; n.pc4 = PCPlus4D; n.imm = ImmExtD;
      n.rd1 = (RegWriteW && RdW != 0 && RdW == Rs1D) ? ResultW : RD1D;
      n.rd2 = (RegWriteW && RdW != 0 && RdW == Rs2D) ? ResultW : RD2D;
      n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD;
      n.v = ValidD;
      if (ValidD) begin
        n.rw = RegWriteD; n.mw = MemWriteD; n.j = JumpD; n.b = BranchD;
        n.as = ALUSrcD; n.rsrc = ResultSrcD; n.alu = ALUControlD;
      end else begin
        n.rw = 0; n.mw = 0; n.j = 0; n.b = 0; n.as = 0; n.rsrc = 0; n.alu = 0;
        n.bc = (cur.bc == 4'hF) ? cur.bc : cur.bc + 4'd1;
      end
    end
    return n;
  endfunction

  task automatic cmp_all(input string tag, input st_t e);
    chk({tag, ".ValidE"}, 64'(ValidE), 64'(e.v));
    chk({tag, ".PCE"}, 64'(PCE), 64'(e.pc));
    chk({tag, ".PCPlus4E"}, 64'(PCPlus4E), 64'(e.pc4));
    chk({tag, ".ImmExtE"}, 64'(ImmExtE), 64'(e.imm));
    chk({tag, ".RD1E"}, 64'(RD1E), 64'(e.rd1));
    chk({tag, ".RD2E"}, 64'(RD2E), 64'(e.rd2));
    chk({tag, ".Rs1E"}, 64'(Rs1E), 64'(e.rs1));
    chk({tag, ".Rs2E"}, 64'(Rs2E), 64'(e.rs2));
    chk({tag, ".RdE"}, 64'(RdE), 64'(e.rd));
    chk({tag, ".ctrl"}, 64'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}),
        64'({e.rw, e.mw, e.j, e.b, e.as, e.rsrc, e.alu}));
    chk({tag, ".BubbleCount"}, 64'(BubbleCount), 64'(e.bc));
  endtask

  // Inputs are already set by the caller (well away from the edge).
  task automatic step(input string tag);
    st_t e;
    m = predict(m);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      cmp_all(tag, e);
    end
  endtask

  task automatic set_d(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic rw);
    ValidD = v; PCD = pc; PCPlus4D = pc + 32'd4; ImmExtD = pc ^ 32'h5A5A;
    RD1D = r1; RD2D = r2; Rs1D = s1; Rs2D = s2; RdD = d; RegWriteD = rw;
    MemWriteD = 0; JumpD = 0; BranchD = 1; ALUSrcD = 1; ResultSrcD = 2'd2; ALUControlD = 3'd5;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, ".ValidE"}, 64'(ValidE), 64'd0);
    chk({tag, ".PCE"}, 64'(PCE), 64'd0);
    chk({tag, ".RD1E"}, 64'(RD1E), 64'd0);
    chk({tag, ".RegWriteE"}, 64'(RegWriteE), 64'd0);
    chk({tag, ".BubbleCount"}, 64'(BubbleCount), 64'd0);
  endtask

  initial begin
    logic [31:0] held_pc;
    rst = 1; StallE = 0; FlushE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    m = '0;
    #1 zero_check("reset");
    @(posedge clk); #1;
    rst = 0;

    // plain load
    set_d(1, 32'h100, 5, 3, 1, 4, 7, 1);
    step("load");
    chk("load.pc_const", 64'(PCE), 64'h100);
    chk("load.rd1_const", 64'(RD1E), 64'd5);
    chk("load.bc_const", 64'(BubbleCount), 64'd0);

    // bypass to both operands, then RdW=0 must not bypass
    set_d(1, 32'h104, 3, 3, 2, 2, 9, 1);
    RegWriteW = 1; RdW = 2; ResultW = 32'hAA;
    step("bypass");
    chk("bypass.rd1_const", 64'(RD1E), 64'hAA);
    chk("bypass.rd2_const", 64'(RD2E), 64'hAA);
    set_d(1, 32'h108, 3, 3, 0, 0, 9, 1);
    RdW = 0;
    step("bypass_x0");
    chk("bypass_x0.rd1_const", 64'(RD1E), 64'd3);
    RegWriteW = 0;

    // stall three cycles with changing D inputs and a matching write port
    held_pc = PCE;
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      set_d(i[0], 32'h200 + 32'(i) * 4, 32'h11 + 32'(i), 32'h22, 0, 0, 5, 1);
      RegWriteW = 1; RdW = 0; ResultW = 32'hBEEF;
      step("stall");
    end
    chk("stall.pc_held", 64'(PCE), 64'(held_pc));
    chk("stall.bc_held", 64'(BubbleCount), 64'd0);
    RegWriteW = 0;
    FlushE = 1;
    step("stall_flush");
    chk("stall_flush.bc_const", 64'(BubbleCount), 64'd1);
    StallE = 0; FlushE = 0;

    // bubble load: data loads, control cleared, counter bumps
    set_d(0, 32'h300, 32'h77, 32'h88, 3, 4, 6, 1);
    step("bubble_load");
    chk("bubble_load.bc_const", 64'(BubbleCount), 64'd2);

    // async reset mid-cycle with a live instruction in E
    set_d(1, 32'h100, 1, 2, 1, 2, 3, 1);
    step("pre_areset");
    #2 rst = 1;
    #1 zero_check("areset");
    m = '0;
    #1 rst = 0;
    set_d(1, 32'h400, 1, 2, 1, 2, 3, 1);
    step("post_areset");
    chk("post_areset.valid_const", 64'(ValidE), 64'd1);

    // randomized traffic, bypass hits are frequent by drawing Rd/Rs from x0..x3
    for (int i = 0; i < 300; i++) begin
      StallE = ($urandom_range(0, 9) == 0);
      FlushE = ($urandom_range(0, 14) == 0);
      ValidD = ($urandom_range(0, 7) != 0);
      PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
      RD1D = $urandom; RD2D = $urandom; ResultW = $urandom;
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      RdD = 5'($urandom); RdW = 5'($urandom_range(0, 3));
      RegWriteW = 1'($urandom); RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
      JumpD = 1'($urandom); BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
      ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
      step("rand");
      if (!ValidE)
        chk("rand.ctrl_zero", 64'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}), 64'd0);
    end

    // saturation from a clean reset
    @(negedge clk);
    rst = 1; StallE = 0; FlushE = 0;
    #1 rst = 0;
    m = '0;
    FlushE = 1;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.bc_const", 64'(BubbleCount), 64'd15);
    FlushE = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipeline_register.md
ID_EX_PIPELINE_REGISTER -- requirements
Module: id_ex_pipeline_register

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all data fields.
REQ-002 Parameter CNT_W, default 16, width of bubble counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 StallE  in  1  hold all E-stage contents.
REQ-006 FlushE  in  1  replace next E-stage contents with a bubble.
REQ-007 ValidD  in  1  decode slot holds a real instruction.
REQ-008 PCD, PCPlus4D, ImmExtD  in  XLEN each  decode-stage PC, PC+4, extended immediate.
REQ-009 RD1D, RD2D  in  XLEN each  register-file read data for Rs1D, Rs2D.
REQ-010 Rs1D, Rs2D, RdD  in  5 each  source and destination register indices.
REQ-011 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control bits.
REQ-012 ResultSrcD  in  2; ALUControlD  in  3  decode control fields.
REQ-013 RegWriteW  in  1; RdW  in  5; ResultW  in  XLEN  writeback-stage write port.
REQ-014 Outputs ValidE, PCE, PCPlus4E, ImmExtE, RD1E, RD2E, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE: out, same widths as D counterparts, registered E-stage copies.
REQ-015 BubbleCount  out  CNT_W  number of bubbles inserted since reset.

Function
REQ-016 Every output SHALL be a flop output; no combinational path from any input to any output.
REQ-017 Latency SHALL be one cycle: D inputs sampled at posedge N appear on E outputs after posedge N.
REQ-018 Priority per posedge: rst > FlushE > StallE > normal load.
REQ-019 Normal load (FlushE=0, StallE=0): all E registers take D values, with bypass per REQ-022.
REQ-020 StallE=1, FlushE=0: all E registers SHALL hold; BubbleCount holds.
REQ-021 FlushE=1 (regardless of StallE): ValidE, RegWriteE, MemWriteE, JumpE, BranchE <= 0; ResultSrcE, ALUControlE, ALUSrcE <= 0; Rs1E, Rs2E, RdE <= 0; data fields (PCE, PCPlus4E, ImmExtE, RD1E, RD2E) <= 0.
REQ-022 Write-through bypass on load: if RegWriteW=1, RdW!=0 and RdW==Rs1D, RD1E <= ResultW, else RD1D; identical rule for Rs2D/RD2E; both may fire same cycle.
REQ-023 Bypass SHALL never fire for RdW=0; register x0 reads stay as presented on RD1D/RD2D.
REQ-024 A load with ValidD=0 SHALL be treated as a bubble: control bits and ValidE loaded as 0, data fields loaded normally.
REQ-025 Bubble counting: BubbleCount += 1 on each posedge where FlushE=1, or a load with ValidD=0.
REQ-026 BubbleCount SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 Stall with RegWriteW match: held RD1E/RD2E SHALL NOT be updated by bypass (hold wins).
REQ-028 Control outputs SHALL be zero whenever ValidE=0.

Reset
REQ-029 rst=1 SHALL immediately (no clock) force all outputs to 0, including ValidE and BubbleCount.
REQ-030 Reset deassertion SHALL not create a bubble count; first posedge after deassertion acts per REQ-018.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; state after release is all-zero.

Verification
REQ-032 Load: ValidD=1, PCD=0x100, RD1D=5, RD2D=3, RdD=7, RegWriteD=1 -> next cycle PCE=0x100, RD1E=5, RD2E=3, RdE=7, RegWriteE=1, ValidE=1.
REQ-033 Bypass: Rs1D=2, Rs2D=2, RD1D=RD2D=3, RegWriteW=1, RdW=2, ResultW=0xAA -> RD1E=RD2E=0xAA; repeat with RdW=0 -> RD1E=RD2E=3.
REQ-034 Stall vs flush: StallE=1 for 3 cycles with changing D inputs -> E outputs unchanged, BubbleCount unchanged; then StallE=1, FlushE=1 -> all control 0, ValidE=0, BubbleCount +1.
REQ-035 Saturation: CNT_W=4, 20 consecutive flush cycles -> BubbleCount=15 and stays 15.
REQ-036 Async reset: assert rst between clock edges with ValidE=1, PCE=0x100 -> outputs 0 before next posedge; release, load ValidD=1 -> ValidE=1 after one posedge, BubbleCount=0.
